pc_fetch_bl: RTL and testbench

Instruction-fetch stage directly downstream of the instruction-memory top. Holds the program counter idle until the loader raises PCstart, then drives RDaddr into instruction memory and captures RDdata qualified by VALIDout. Fetched words, paired with their PC, are queued in a 2-entry buffer and handed to decode over a valid/ready handshake. The stage also accepts branch redirects and, optionally, stops on a halt word.

---
 rtl/pcfetch_pkg.sv | 24 ++
 rtl/pc_fetch_bl_if.sv | 27 ++
 rtl/fetch_skid_buf_bl.sv | 77 +++++++
 rtl/pc_fetch_bl.sv | 123 ++++++++++++
 tb/tb_pc_fetch_bl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcfetch_pkg.sv
// Shared types and default constants for the pc_fetch_bl instruction-fetch stage.
// The HALT state is only reachable when PCFETCH_HALT_EN is defined.
package pcfetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_ADDR_STEP = 32'd4;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_fetch_bl_if.sv
// Memory-side, decode-side and control signals of pc_fetch_bl.
// master = fetch stage, slave = surrounding memory/decode/loader.
interface pc_fetch_bl_if;

    logic        PCstart;
    logic        VALIDout;
    logic [31:0] RDdata;
    logic [31:0] RDaddr;
    logic        BRtaken;
    logic [31:0] BRtarget;
    logic        INSTvalid;
    logic        INSTready;
    logic [31:0] INSTout;
    logic [31:0] PCout;
    logic        HALTED;

    modport master (
        input  PCstart, VALIDout, RDdata, BRtaken, BRtarget, INSTready,
        output RDaddr, INSTvalid, INSTout, PCout, HALTED
    );

    modport slave (
        output PCstart, VALIDout, RDdata, BRtaken, BRtarget, INSTready,
        input  RDaddr, INSTvalid, INSTout, PCout, HALTED
    );

endinterface

// File: rtl/fetch_skid_buf_bl.sv
// Two-entry FIFO of {pc, inst} entries; head and valid are registered outputs.
module fetch_skid_buf_bl
    import pcfetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output logic [1:0]   count_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;
    logic         do_pop;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        // Flush wins over push/pop; a same-cycle pop is simply absorbed by it.
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push_i, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_d    = din_i;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        e1_d    = din_i;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = din_i;
                    end else begin
                        e0_d = din_i;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign head_o  = e0_q;

endmodule

// File: rtl/pc_fetch_bl.sv
// Instruction-fetch stage: PC sequencing, one-deep request tracking, redirects.
// Optional halt-on-HALT_WORD behaviour is built only with PCFETCH_HALT_EN defined.
module pc_fetch_bl
    import pcfetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] ADDR_STEP = DEF_ADDR_STEP,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
)(
    input  logic          clk,
    input  logic          RSTcount,
    pc_fetch_bl_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic         halted_q, halted_d;

    logic         push, pop, flush;
    logic         buf_valid;
    logic [1:0]   count;
    logic [2:0]   occ;
    logic         issue_ok;
    logic         halt_hit;
    logic [31:0]  resp_pc;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    always_comb begin
        pop      = buf_valid & bus.INSTready;
        occ      = {1'b0, count} - {2'b00, pop} + {2'b00, inflight_q};
        issue_ok = (occ <= 3'd1);
        // PC already advanced past the outstanding request, so step back to name it.
        resp_pc         = pc_q - ADDR_STEP;
        push_entry.pc   = resp_pc;
        push_entry.inst = bus.RDdata;
`ifdef PCFETCH_HALT_EN
        halt_hit = inflight_q && bus.VALIDout && (bus.RDdata == HALT_WORD);
`else
        halt_hit = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        halted_d   = halted_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.BRtaken) begin
                    flush = 1'b1;
                    pc_d  = word_align(bus.BRtarget);
                end else if (bus.PCstart) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.BRtaken) begin
                    flush = 1'b1;
                    pc_d  = word_align(bus.BRtarget);
                end else if (inflight_q && !bus.VALIDout) begin
                    pc_d = resp_pc;
                end else if (halt_hit) begin
                    state_d = HALT;
                end else begin
                    push = inflight_q;
                    if (issue_ok) begin
                        inflight_d = 1'b1;
                        pc_d       = pc_q + ADDR_STEP;
                    end
                end
            end
`ifdef PCFETCH_HALT_EN
            HALT: begin
                halted_d = halted_q | (count == 2'd0);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RSTcount) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    fetch_skid_buf_bl u_buf (
        .clk     (clk),
        .rst     (RSTcount),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (push_entry),
        .count_o (count),
        .valid_o (buf_valid),
        .head_o  (head)
    );

    assign bus.RDaddr    = pc_q;
    assign bus.INSTvalid = buf_valid;
    assign bus.INSTout   = head.inst;
    assign bus.PCout     = head.pc;
    assign bus.HALTED    = halted_q;

`ifndef PCFETCH_HALT_EN
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
`endif

endmodule

// File: tb/tb_pc_fetch_bl.sv
// Bench for pc_fetch_bl: per-cycle vector table for start-up plus scoreboarded
// corner-case sequences (stall, retry, redirect, wrap, halt).
module tb_pc_fetch_bl;
    import pcfetch_pkg::*;

    logic clk;
    logic rst;

    pc_fetch_bl_if bus ();
    pc_fetch_bl_if bus_w ();

    pc_fetch_bl u_dut (
        .clk      (clk),
        .RSTcount (rst),
        .bus      (bus.master)
    );

    pc_fetch_bl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (
        .clk      (clk),
        .RSTcount (rst),
        .bus      (bus_w.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data for the address presented in the previous cycle.
    logic [31:0] prev_a, prev_w;
    logic [31:0] drop_addr;
    logic        halt_en;
    int unsigned drop_req;
    int unsigned drop_done = 0;

    always @(posedge clk) begin
        if (drop_req != drop_done && prev_a == drop_addr) drop_done <= drop_done + 1;
        prev_a <= bus.RDaddr;
        prev_w <= bus_w.RDaddr;
    end

    assign bus.VALIDout   = !(drop_req != drop_done && prev_a == drop_addr);
    assign bus.RDdata     = (halt_en && prev_a == 32'h0000_000C) ? 32'hFFFF_FFFF : prev_a;
    assign bus_w.VALIDout = 1'b1;
    assign bus_w.RDdata   = prev_w;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    fetch_entry_t sb[$];

    typedef struct {
        logic        start;
        logic        ready;
        logic [31:0] rdaddr;
        logic        valid;
        logic [31:0] pcout;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_stream(input logic [31:0] base, input int unsigned n);
        fetch_entry_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.pc   = base + 32'(4 * i);
            e.inst = e.pc;
            sb.push_back(e);
        end
    endtask

    // Compares any pop happening at the coming edge, then advances one cycle.
    task automatic tick();
        fetch_entry_t e;
        if (bus.INSTvalid === 1'b1 && bus.INSTready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected: got pc %h, expected no delivery", bus.PCout);
            end else begin
                e = sb.pop_front();
                check("sb_pc", bus.PCout, e.pc);
                check("sb_inst", bus.INSTout, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.INSTready   = 1'b0;
        bus.PCstart     = 1'b0;
        bus.BRtaken     = 1'b0;
        bus_w.PCstart   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_rdaddr", bus.RDaddr, 32'h0);
        check("rst_valid", {31'b0, bus.INSTvalid}, 32'h0);
        check("rst_instout", bus.INSTout, 32'h0);
        check("rst_pcout", bus.PCout, 32'h0);
        check("rst_halted", {31'b0, bus.HALTED}, 32'h0);
        check("rst_w_rdaddr", bus_w.RDaddr, 32'hFFFF_FFF8);
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        fetch_entry_t e;
        tbl[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[3] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[4] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[5] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[6] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};

        drop_req        = 0;
        drop_addr       = 32'h0;
        halt_en         = 1'b0;
        bus.BRtarget    = 32'h0;
        bus_w.BRtaken   = 1'b0;
        bus_w.BRtarget  = 32'h0;
        bus_w.INSTready = 1'b1;
        rst             = 1'b1;

        // Start-up and streaming, then a 10-cycle stall, then mid-stream reset.
        reset_dut();
        sb_stream(32'h0, 64);
        for (int i = 0; i < 7; i++) begin
            bus.PCstart   = tbl[i].start;
            bus.INSTready = tbl[i].ready;
            tick();
            check($sformatf("tbl%0d_rdaddr", i), bus.RDaddr, tbl[i].rdaddr);
            check($sformatf("tbl%0d_valid", i), {31'b0, bus.INSTvalid}, {31'b0, tbl[i].valid});
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d_pcout", i), bus.PCout, tbl[i].pcout);
                check($sformatf("tbl%0d_instout", i), bus.INSTout, tbl[i].pcout);
            end
        end
        repeat (3) tick();
        bus.INSTready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_rdaddr", bus.RDaddr, 32'h20);
            check("stall_valid", {31'b0, bus.INSTvalid}, 32'h1);
            check("stall_pcout", bus.PCout, 32'h18);
        end
        bus.INSTready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("release_no_gap", {31'b0, bus.INSTvalid}, 32'h1);
        end
        reset_dut();

        // Unanswered fetch of address 8 is reissued.
        drop_addr = 32'h8;
        drop_req  = drop_req + 1;
        sb_stream(32'h0, 32);
        bus.INSTready = 1'b1;
        bus.PCstart   = 1'b1;
        tick();
        bus.PCstart = 1'b0;
        repeat (3) tick();
        check("retry_c4_rdaddr", bus.RDaddr, 32'h0C);
        tick();
        check("retry_reissue", bus.RDaddr, 32'h08);
        tick();
        check("retry_c6_rdaddr", bus.RDaddr, 32'h0C);
        repeat (6) tick();
        reset_dut();

        // Redirect in FETCH with one entry buffered, one response arriving, and a pop.
        bus.PCstart = 1'b1;
        tick();
        bus.PCstart = 1'b0;
        tick();
        tick();
        check("br_pre_valid", {31'b0, bus.INSTvalid}, 32'h1);
        check("br_pre_rdaddr", bus.RDaddr, 32'h08);
        sb_stream(32'h0, 1);
        bus.INSTready = 1'b1;
        bus.BRtaken   = 1'b1;
        bus.BRtarget  = 32'h0000_0103;
        tick();
        bus.BRtaken = 1'b0;
        check("br_flush_valid", {31'b0, bus.INSTvalid}, 32'h0);
        check("br_rdaddr", bus.RDaddr, 32'h100);
        check("br_pop_consumed", 32'(sb.size()), 32'h0);
        sb_stream(32'h100, 32);
        tick();
        check("br_c5_rdaddr", bus.RDaddr, 32'h104);
        tick();
        check("br_first_valid", {31'b0, bus.INSTvalid}, 32'h1);
        check("br_first_pcout", bus.PCout, 32'h100);
        repeat (5) tick();
        reset_dut();

        // Redirect while IDLE loads the PC but does not start fetching.
        bus.BRtaken  = 1'b1;
        bus.BRtarget = 32'h0000_0203;
        tick();
        bus.BRtaken = 1'b0;
        check("idle_br_rdaddr", bus.RDaddr, 32'h200);
        check("idle_br_valid", {31'b0, bus.INSTvalid}, 32'h0);
        tick();
        tick();
        check("idle_hold_rdaddr", bus.RDaddr, 32'h200);
        sb_stream(32'h200, 16);
        bus.INSTready = 1'b1;
        bus.PCstart   = 1'b1;
        tick();
        bus.PCstart = 1'b0;
        check("idle_start_rdaddr", bus.RDaddr, 32'h200);
        tick();
        check("idle_next_rdaddr", bus.RDaddr, 32'h204);
        repeat (4) tick();
        reset_dut();

        // PC wrap on the instance with RESET_PC = FFFF_FFF8.
        bus_w.PCstart = 1'b1;
        tick();
        bus_w.PCstart = 1'b0;
        check("wrap_c1_rdaddr", bus_w.RDaddr, 32'hFFFF_FFF8);
        tick();
        check("wrap_c2_rdaddr", bus_w.RDaddr, 32'hFFFF_FFFC);
        tick();
        check("wrap_c3_rdaddr", bus_w.RDaddr, 32'h0000_0000);
        check("wrap_c3_pcout", bus_w.PCout, 32'hFFFF_FFF8);
        tick();
        check("wrap_c4_pcout", bus_w.PCout, 32'hFFFF_FFFC);
        check("wrap_c4_rdaddr", bus_w.RDaddr, 32'h0000_0004);
        tick();
        check("wrap_c5_pcout", bus_w.PCout, 32'h0000_0000);
        check("wrap_c5_instout", bus_w.INSTout, 32'h0000_0000);
        reset_dut();

        // HALT_WORD at address 0xC.
        halt_en = 1'b1;
`ifdef PCFETCH_HALT_EN
        sb_stream(32'h0, 3);
        bus.INSTready = 1'b1;
        bus.PCstart   = 1'b1;
        tick();
        bus.PCstart = 1'b0;
        repeat (4) tick();
        check("halt_c5_halted", {31'b0, bus.HALTED}, 32'h0);
        check("halt_c5_pcout", bus.PCout, 32'h08);
        repeat (4) tick();
        check("halt_halted", {31'b0, bus.HALTED}, 32'h1);
        check("halt_valid", {31'b0, bus.INSTvalid}, 32'h0);
        check("halt_rdaddr", bus.RDaddr, 32'h10);
        check("halt_drained", 32'(sb.size()), 32'h0);
        bus.BRtaken  = 1'b1;
        bus.BRtarget = 32'h0000_0300;
        bus.PCstart  = 1'b1;
        tick();
        bus.BRtaken = 1'b0;
        bus.PCstart = 1'b0;
        tick();
        check("halt_br_halted", {31'b0, bus.HALTED}, 32'h1);
        check("halt_br_rdaddr", bus.RDaddr, 32'h10);
        check("halt_br_valid", {31'b0, bus.INSTvalid}, 32'h0);
`else
        sb_stream(32'h0, 3);
        e.pc   = 32'h0C;
        e.inst = 32'hFFFF_FFFF;
        sb.push_back(e);
        sb_stream(32'h10, 1);
        bus.INSTready = 1'b1;
        bus.PCstart   = 1'b1;
        tick();
        bus.PCstart = 1'b0;
        repeat (7) tick();
        check("haltword_delivered", 32'(sb.size()), 32'h0);
        check("haltword_halted", {31'b0, bus.HALTED}, 32'h0);
`endif
        halt_en = 1'b0;
        reset_dut();
        tick();
        tick();
        check("post_reset_idle_rdaddr", bus.RDaddr, 32'h0);
        check("post_reset_idle_valid", {31'b0, bus.INSTvalid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
